// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM stage for a split-handshake data SRAM: waits for load data, aligns/extends it, drops orphaned responses.
module mem_stage_hs #(
  parameter int CNT_W  = 2,
  parameter int EXC_W  = 5,
  parameter int FWD_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             es_to_ms_valid,
  output logic             ms_allowin,
  input  logic [31:0]      es_pc,
  input  logic [31:0]      es_addr,
  input  logic [2:0]       es_ld_op,
  input  logic             es_mem_req,
  input  logic [31:0]      es_rt_value,
  input  logic             es_gr_we,
  input  logic [4:0]       es_dest,
  input  logic             es_ex,
  input  logic [EXC_W-1:0] es_excode,
  input  logic             data_sram_data_ok,
  input  logic [31:0]      data_sram_rdata,
  output logic             ms_cancel_busy,
  input  logic             ws_allowin,
  input  logic             ex_from_ws,
  output logic             ms_to_ws_valid,
  output logic [31:0]      ms_pc,
  output logic [31:0]      ms_result,
  output logic             ms_gr_we,
  output logic [4:0]       ms_dest,
  output logic             ms_ex,
  output logic [EXC_W-1:0] ms_excode,
  output logic             ms_fwd_valid,
  output logic             ms_fwd_blocked,
  output logic [4:0]       ms_fwd_dest,
  output logic [31:0]      ms_fwd_data
);
  logic             r_valid, r_req, r_buf_valid, r_gr_we, r_ex;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_buf, r_pc, r_addr, r_rt;
  logic [2:0]       r_ld_op;
  logic [4:0]       r_dest;
  logic [EXC_W-1:0] r_excode;
  logic             w_stale, w_ok, w_ready_go, w_inc, w_fwd_valid;
  logic [1:0]       w_a;
  logic [31:0]      w_d, w_sh, w_lwl, w_lwr, w_load;
  logic [15:0]      w_half;
  // a response arriving while cancelled loads are outstanding belongs to one of them
  assign w_stale        = data_sram_data_ok & (r_cnt != '0);
  assign w_ok           = data_sram_data_ok & (r_cnt == '0);
  assign w_ready_go     = !r_req | w_ok | r_buf_valid;
  assign ms_allowin     = !r_valid | (w_ready_go & ws_allowin);
  assign ms_to_ws_valid = r_valid & w_ready_go & !ex_from_ws;
  assign ms_cancel_busy = r_cnt != '0;
  assign w_inc          = ex_from_ws & r_valid & r_req & !r_buf_valid & !w_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_buf_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_valid <= ex_from_ws ? 1'b0 : ms_allowin ? es_to_ms_valid : r_valid;
      r_cnt   <= r_cnt + CNT_W'(w_inc) - CNT_W'(w_stale);
      if (ex_from_ws || (ms_to_ws_valid && ws_allowin))
        r_buf_valid <= 1'b0;
      else if (r_valid && r_req && w_ok && !ws_allowin)
        r_buf_valid <= 1'b1;
      if (w_inc && !w_stale)
        assert (r_cnt != '1) else $error("cancel counter overflow");
    end
  end
  always_ff @(posedge clk) begin
    if (r_valid && r_req && w_ok && !ws_allowin && !r_buf_valid)
      r_buf <= data_sram_rdata;
    if (es_to_ms_valid && ms_allowin) begin
      r_pc     <= es_pc;
      r_addr   <= es_addr;
      r_ld_op  <= es_ld_op;
      r_req    <= es_mem_req;
      r_rt     <= es_rt_value;
      r_gr_we  <= es_gr_we;
      r_dest   <= es_dest;
      r_ex     <= es_ex;
      r_excode <= es_excode;
    end
  end
  assign w_a    = r_addr[1:0];
  assign w_d    = r_buf_valid ? r_buf : data_sram_rdata;
  assign w_sh   = w_d >> {w_a, 3'b0};
  assign w_half = r_addr[1] ? w_d[31:16] : w_d[15:0];
  assign w_lwl  = (w_d << {~w_a, 3'b0}) | (r_rt & (32'h00FF_FFFF >> {w_a, 3'b0}));
  assign w_lwr  = w_sh | (r_rt & ~(32'hFFFF_FFFF >> {w_a, 3'b0}));
  always_comb begin
    w_load = r_addr;
    case (r_ld_op)
      3'd1: w_load = w_d;
      3'd2: w_load = {{24{w_sh[7]}}, w_sh[7:0]};
      3'd3: w_load = {24'b0, w_sh[7:0]};
      3'd4: w_load = {{16{w_half[15]}}, w_half};
      3'd5: w_load = {16'b0, w_half};
      3'd6: w_load = w_lwl;
      3'd7: w_load = w_lwr;
      default: w_load = r_addr;
    endcase
  end
  assign ms_pc       = r_pc;
  assign ms_result   = w_load;
  assign ms_gr_we    = r_gr_we & !r_ex;
  assign ms_dest     = r_dest;
  assign ms_ex       = r_ex;
  assign ms_excode   = r_excode;
  assign w_fwd_valid = (FWD_EN != 0) & r_valid & ms_gr_we;
  assign ms_fwd_valid   = w_fwd_valid;
  assign ms_fwd_blocked = w_fwd_valid & r_req & (r_ld_op != 3'd0) & !(w_ok | r_buf_valid);
  assign ms_fwd_dest    = w_fwd_valid ? r_dest : 5'd0;
  assign ms_fwd_data    = w_fwd_valid ? w_load : 32'd0;
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed bench for mem_stage_hs; expected WB results are queued at issue and popped on handoff.
module tb_mem_stage_hs;
  logic        clk = 1'b0, reset;
  logic        es_to_ms_valid, ms_allowin, es_mem_req, es_gr_we, es_ex;
  logic [31:0] es_pc, es_addr, es_rt_value;
  logic [2:0]  es_ld_op;
  logic [4:0]  es_dest, es_excode;
  logic        data_sram_data_ok, ms_cancel_busy, ws_allowin, ex_from_ws, ms_to_ws_valid;
  logic [31:0] data_sram_rdata, ms_pc, ms_result, ms_fwd_data;
  logic        ms_gr_we, ms_ex, ms_fwd_valid, ms_fwd_blocked;
  logic [4:0]  ms_dest, ms_excode, ms_fwd_dest;
  int          n_chk = 0, n_err = 0, n_exp = 0, n_got = 0;
  logic [63:0] q[$];
  always #5 clk = ~clk;
  mem_stage_hs dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_addr(es_addr), .es_ld_op(es_ld_op), .es_mem_req(es_mem_req),
    .es_rt_value(es_rt_value), .es_gr_we(es_gr_we), .es_dest(es_dest), .es_ex(es_ex),
    .es_excode(es_excode), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ms_cancel_busy(ms_cancel_busy), .ws_allowin(ws_allowin), .ex_from_ws(ex_from_ws),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_result(ms_result), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .ms_ex(ms_ex), .ms_excode(ms_excode), .ms_fwd_valid(ms_fwd_valid),
    .ms_fwd_blocked(ms_fwd_blocked), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic samp();
    logic [63:0] e;
    @(negedge clk);
    if (ms_to_ws_valid && ws_allowin) begin
      n_got++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wb_pc", ms_pc, e[63:32]);
        chk("wb_result", ms_result, e[31:0]);
      end
    end
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic [2:0] op,
                       input logic [31:0] rt, input logic req, input logic [31:0] exp, input logic push);
    es_to_ms_valid = 1'b1; es_pc = pc; es_addr = addr; es_ld_op = op; es_mem_req = req;
    es_rt_value = rt; es_gr_we = 1'b1; es_dest = pc[6:2];
    if (push) begin
      q.push_back({pc, exp});
      n_exp++;
    end
    samp();
    chk("allowin_cap", 32'(ms_allowin), 1);
    adv();
    es_to_ms_valid = 1'b0;
  endtask
  task automatic resp(input logic [31:0] rd);
    data_sram_data_ok = 1'b1; data_sram_rdata = rd;
    samp();
    adv();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0BAD_0BAD;
  endtask
  task automatic load(input logic [31:0] pc, input logic [31:0] addr, input logic [2:0] op,
                      input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp, input int wt);
    issue(pc, addr, op, rt, 1'b1, exp, 1'b1);
    for (int i = 0; i < wt; i++) begin
      samp();
      chk("fwd_blocked_wait", 32'(ms_fwd_blocked), 1);
      chk("wait_no_valid", 32'(ms_to_ws_valid), 0);
      adv();
    end
    resp(rd);
  endtask
  initial begin
    reset = 1'b1; es_to_ms_valid = 1'b0; es_pc = '0; es_addr = '0; es_ld_op = '0; es_mem_req = 1'b0;
    es_rt_value = '0; es_gr_we = 1'b0; es_dest = '0; es_ex = 1'b0; es_excode = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_allowin = 1'b1; ex_from_ws = 1'b0;
    adv();
    samp();
    chk("rst_to_ws_valid", 32'(ms_to_ws_valid), 0);
    chk("rst_busy", 32'(ms_cancel_busy), 0);
    chk("rst_fwd_valid", 32'(ms_fwd_valid), 0);
    chk("rst_fwd_blocked", 32'(ms_fwd_blocked), 0);
    chk("rst_allowin", 32'(ms_allowin), 1);
    adv();
    reset = 1'b0;
    load(32'h1000, 32'h100, 3'd1, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    load(32'h1004, 32'h103, 3'd2, 32'h0, 32'h80FF_0000, 32'hFFFF_FF80, 1);
    load(32'h1008, 32'h103, 3'd3, 32'h0, 32'h80FF_0000, 32'h0000_0080, 0);
    load(32'h100C, 32'h102, 3'd5, 32'h0, 32'h80FF_0000, 32'h0000_80FF, 0);
    load(32'h1010, 32'h100, 3'd4, 32'h0, 32'h0000_8001, 32'hFFFF_8001, 2);
    load(32'h1014, 32'h001, 3'd6, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344, 0);
    load(32'h1018, 32'h001, 3'd7, 32'h1122_3344, 32'hAABB_CCDD, 32'h11AA_BBCC, 0);
    load(32'h101C, 32'h003, 3'd6, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD, 0);
    load(32'h1020, 32'h003, 3'd7, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_33AA, 0);
    load(32'h1024, 32'h000, 3'd6, 32'h1122_3344, 32'hAABB_CCDD, 32'hDD22_3344, 0);
    load(32'h1028, 32'h000, 3'd7, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD, 0);
    // non-memory op completes in the cycle it sits in MEM and forwards its ALU result
    issue(32'h1030, 32'h1234_5678, 3'd0, 32'h0, 1'b0, 32'h1234_5678, 1'b1);
    samp();
    chk("alu_gr_we", 32'(ms_gr_we), 1);
    chk("alu_dest", 32'(ms_dest), 12);
    chk("alu_fwd_valid", 32'(ms_fwd_valid), 1);
    chk("alu_fwd_blocked", 32'(ms_fwd_blocked), 0);
    chk("alu_fwd_dest", 32'(ms_fwd_dest), 12);
    chk("alu_fwd_data", ms_fwd_data, 32'h1234_5678);
    adv();
    es_ex = 1'b1; es_excode = 5'h0C;
    issue(32'h1034, 32'h0000_CAFE, 3'd0, 32'h0, 1'b0, 32'h0000_CAFE, 1'b1);
    es_ex = 1'b0; es_excode = 5'h00;
    samp();
    chk("ex_pass", 32'(ms_ex), 1);
    chk("ex_code", 32'(ms_excode), 32'h0C);
    chk("ex_gr_we", 32'(ms_gr_we), 0);
    chk("ex_fwd_valid", 32'(ms_fwd_valid), 0);
    adv();
    issue(32'h1040, 32'h100, 3'd1, 32'h0, 1'b1, 32'h1357_2468, 1'b1);
    ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1357_2468;
    samp();
    chk("early_valid", 32'(ms_to_ws_valid), 1);
    adv();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      samp();
      chk("buf_result", ms_result, 32'h1357_2468);
      chk("buf_valid_out", 32'(ms_to_ws_valid), 1);
      chk("buf_allowin", 32'(ms_allowin), 0);
      chk("buf_fwd_blocked", 32'(ms_fwd_blocked), 0);
      adv();
    end
    ws_allowin = 1'b1;
    samp();
    adv();
    samp();
    chk("buf_drained", 32'(ms_to_ws_valid), 0);
    adv();
    // flushed load leaves its response in flight; it must be swallowed
    issue(32'h1050, 32'h100, 3'd1, 32'h0, 1'b1, 32'h0, 1'b0);
    ex_from_ws = 1'b1;
    samp();
    chk("flush_valid", 32'(ms_to_ws_valid), 0);
    adv();
    ex_from_ws = 1'b0;
    samp();
    chk("flush_busy", 32'(ms_cancel_busy), 1);
    chk("flush_allowin", 32'(ms_allowin), 1);
    adv();
    resp(32'hFFFF_FFFF);
    samp();
    chk("drop_valid", 32'(ms_to_ws_valid), 0);
    chk("drop_busy", 32'(ms_cancel_busy), 0);
    adv();
    load(32'h1054, 32'h100, 3'd1, 32'h0, 32'h2468_1357, 32'h2468_1357, 1);
    issue(32'h1060, 32'h100, 3'd1, 32'h0, 1'b1, 32'h0, 1'b0);
    ex_from_ws = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_7777;
    samp();
    chk("flush_ok_valid", 32'(ms_to_ws_valid), 0);
    adv();
    ex_from_ws = 1'b0; data_sram_data_ok = 1'b0;
    samp();
    chk("flush_ok_busy", 32'(ms_cancel_busy), 0);
    adv();
    load(32'h1064, 32'h100, 3'd1, 32'h0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 0);
    issue(32'h1070, 32'h100, 3'd1, 32'h0, 1'b1, 32'h0, 1'b0);
    samp();
    chk("rst_mid_blocked", 32'(ms_fwd_blocked), 1);
    adv();
    reset = 1'b1;
    adv();
    samp();
    chk("rst_mid_valid", 32'(ms_to_ws_valid), 0);
    chk("rst_mid_fwd", 32'(ms_fwd_valid), 0);
    chk("rst_mid_allowin", 32'(ms_allowin), 1);
    adv();
    reset = 1'b0;
    issue(32'h1074, 32'h100, 3'd1, 32'h0, 1'b1, 32'h0, 1'b0);
    ex_from_ws = 1'b1;
    samp();
    adv();
    ex_from_ws = 1'b0;
    samp();
    chk("pre_rst_busy", 32'(ms_cancel_busy), 1);
    adv();
    reset = 1'b1;
    adv();
    reset = 1'b0;
    samp();
    chk("rst_clears_busy", 32'(ms_cancel_busy), 0);
    adv();
    load(32'h1078, 32'h102, 3'd4, 32'h0, 32'h8001_0000, 32'hFFFF_8001, 0);
    chk("handoffs", n_got, n_exp);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
